// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use and branch-operand stall/flush control with a HOLD FSM for two-cycle branch stalls; HAZARD_PERF_CNT_EN builds saturating stall/flush counters
module hazard_stall_unit #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 32
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [REG_BITS-1:0] If_Id_Rs,
  input  logic [REG_BITS-1:0] If_Id_Rt,
  input  logic                If_Id_UsesRt,
  input  logic                If_Id_Branch,
  input  logic                Branch_Taken,
  input  logic                Jump,
  input  logic [REG_BITS-1:0] Id_Ex_Rd,
  input  logic                Id_Ex_RegWrite,
  input  logic                Id_Ex_MemRead,
  input  logic [REG_BITS-1:0] Ex_Mem_Rd,
  input  logic                Ex_Mem_MemRead,
  input  logic                Mem_Stall,
  output logic                PC_Write,
  output logic                If_Id_Write,
  output logic                Id_Ex_Bubble,
  output logic                Pipe_Freeze,
  output logic                If_Id_Flush,
  output logic [CNT_BITS-1:0] Stall_Cycles,
  output logic [CNT_BITS-1:0] Flush_Count
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_n;
  logic remain, remain_n;
  logic id_ex_hit, ex_mem_hit, load_use, br_alu, br_load2, br_load1, hazard, stall;
  // register 0 is hardwired, so a zero destination never matches
  assign id_ex_hit  = (Id_Ex_Rd != '0) && (Id_Ex_Rd == If_Id_Rs || (If_Id_UsesRt && Id_Ex_Rd == If_Id_Rt));
  assign ex_mem_hit = (Ex_Mem_Rd != '0) && (Ex_Mem_Rd == If_Id_Rs || (If_Id_UsesRt && Ex_Mem_Rd == If_Id_Rt));
  assign load_use   = Id_Ex_MemRead && id_ex_hit;
  assign br_alu     = If_Id_Branch && Id_Ex_RegWrite && !Id_Ex_MemRead && id_ex_hit;
  assign br_load2   = If_Id_Branch && Id_Ex_MemRead && id_ex_hit;
  assign br_load1   = If_Id_Branch && Ex_Mem_MemRead && ex_mem_hit;
  assign hazard     = load_use || br_alu || br_load2 || br_load1;
  assign stall      = (state == IDLE && hazard) || state == HOLD;
  // next state: a branch on a load in EX needs one extra HOLD cycle; a memory freeze holds everything
  always_comb begin
    state_n  = state;
    remain_n = remain;
    if (!Mem_Stall && state == IDLE && br_load2) begin
      state_n  = HOLD;
      remain_n = 1'b1;
    end else if (!Mem_Stall && state == HOLD) begin
      remain_n = remain - 1'b1;
      state_n  = (remain == 1'b1) ? IDLE : HOLD;
    end
  end
  // control outputs: reset forces free-running flow, then memory freeze, then stall, then flush
  always_comb begin
    PC_Write     = Rst || (!Mem_Stall && !stall);
    If_Id_Write  = Rst || (!Mem_Stall && !stall);
    Id_Ex_Bubble = !Rst && !Mem_Stall && stall;
    Pipe_Freeze  = !Rst && Mem_Stall;
    If_Id_Flush  = !Rst && !Mem_Stall && !stall && ((If_Id_Branch && Branch_Taken) || Jump);
  end
  // FSM state register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      remain <= 1'b0;
    end else begin
      state  <= state_n;
      remain <= remain_n;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  // saturating counters of real stall cycles and issued flushes
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Stall_Cycles <= '0;
      Flush_Count  <= '0;
    end else begin
      if (stall && !Mem_Stall && Stall_Cycles != '1) Stall_Cycles <= Stall_Cycles + CNT_BITS'(1);
      if (If_Id_Flush && Flush_Count != '1) Flush_Count <= Flush_Count + CNT_BITS'(1);
    end
  end
`else
  assign Stall_Cycles = '0;
  assign Flush_Count  = '0;
`endif
endmodule
